// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl - time-multiplexed scan controller for an 8-digit
// seven-segment display.
//
// Steps a 3-bit digit select through 0..7, one slot of CLK_DIV cycles per
// digit. It decodes the selected nibble of a per-frame snapshot of the display
// word to active-low segments. It drives active-low anodes, with DEAD_CYCLES
// of blanking at the start of each slot so the previous digit cannot ghost
// onto the next one.
//
// Optional feature: define SCAN_LZB_EN to enable leading-zero blanking.
// Digit i (i>=1) goes dark when snapshot nibbles i..7 are all zero.
// Digit 0 is never blanked this way.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset (wins over en)
//   en           in   scan enable
//   data_i       in   32-bit display word, nibble i -> digit i (7 = MSD)
//   blank_mask   in   per-digit force-dark, sampled live
//   sel_o        out  current digit index (mux select)
//   dig_an_o     out  anodes, active-low, one-hot-low or all high
//   seg_o        out  {g,f,e,d,c,b,a}, active-low
//   frame_done_o out  1-cycle pulse after the digit 7 slot ends
module seg_scan_ctrl #(
  parameter int CLK_DIV     = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] data_i,
  input  logic [7:0]  blank_mask,
  output logic [2:0]  sel_o,
  output logic [7:0]  dig_an_o,
  output logic [6:0]  seg_o,
  output logic        frame_done_o
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW:0]   DEAD     = (CW+1)'(DEAD_CYCLES);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [31:0]   snap_q, snap_d;
  logic          run_q, run_d;      // 1 once the snapshot is loaded for this run
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          fd_q, fd_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic        div_wrap;
  logic        load_idle;
  logic [31:0] view;       // word the current digit is decoded from
  logic [3:0]  nib;
  logic        lzb_dark;
  logic        dark;

  assign div_wrap  = (div_cnt_q == DIV_LAST);
  assign load_idle = en && !run_q;
  // On the first enabled cycle the snapshot is loading this very edge, so
  // decode straight from data_i to keep that cycle consistent even when
  // DEAD_CYCLES is 0.
  assign view = load_idle ? data_i : snap_q;
  assign nib  = view[{sel_q, 2'b00} +: 4];

`ifdef SCAN_LZB_EN
  assign lzb_dark = (sel_q != 3'd0) && ((view >> {sel_q, 2'b00}) == 32'd0);
`else
  assign lzb_dark = 1'b0;
`endif

  assign dark = !en || ({1'b0, div_cnt_q} < DEAD) || blank_mask[sel_q] || lzb_dark;

  always_comb begin
    div_cnt_d = div_cnt_q;
    sel_d     = sel_q;
    snap_d    = snap_q;
    run_d     = run_q;
    fd_d      = 1'b0;
    an_d      = 8'hFF;
    seg_d     = 7'h7F;
    if (!en) begin
      // Pause: the held digit restarts with a full slot on resume.
      div_cnt_d = '0;
      run_d     = 1'b0;
    end else begin
      run_d = 1'b1;
      if (!run_q) snap_d = data_i;
      if (div_wrap) begin
        div_cnt_d = '0;
        sel_d     = sel_q + 3'd1;
        if (sel_q == 3'd7) begin
          fd_d   = 1'b1;
          snap_d = data_i;
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
      if (!dark) begin
        an_d  = ~(8'b1 << sel_q);
        seg_d = hex7(nib);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      sel_q     <= '0;
      snap_q    <= '0;
      run_q     <= 1'b0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      fd_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sel_q     <= sel_d;
      snap_q    <= snap_d;
      run_q     <= run_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      fd_q      <= fd_d;
    end
  end

  assign sel_o        = sel_q;
  assign dig_an_o     = an_q;
  assign seg_o        = seg_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl (CLK_DIV=4, DEAD_CYCLES=1) against a
// position-in-frame reference model.
module tb_seg_scan_ctrl;
  localparam int CD   = 4;
  localparam int DEAD = 1;
  localparam int FRAME = 8 * CD;

  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst, en;
  logic [31:0] data_i;
  logic [7:0]  blank_mask;
  logic [2:0]  sel_o;
  logic [7:0]  dig_an_o;
  logic [6:0]  seg_o;
  logic        frame_done_o;

  int n_chk  = 0;
  int n_fail = 0;

  seg_scan_ctrl #(.CLK_DIV(CD), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .rst(rst), .en(en), .data_i(data_i), .blank_mask(blank_mask),
    .sel_o(sel_o), .dig_an_o(dig_an_o), .seg_o(seg_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: position within the frame, the frame snapshot, and
  // whether a snapshot has been taken since the last reset/idle period.
  int          m_pos;
  logic [31:0] m_snap;
  bit          m_run;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_fd;

  function automatic bit lzb(input logic [31:0] w, input int d);
`ifdef SCAN_LZB_EN
    return (d >= 1) && ((w >> (4 * d)) == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    int d, c;
    logic [31:0] w;
    if (rst) begin
      m_pos = 0; m_snap = '0; m_run = 0;
      e_an = 8'hFF; e_seg = 7'h7F; e_fd = 0;
    end else if (!en) begin
      m_pos = (m_pos / CD) * CD;
      m_run = 0;
      e_an = 8'hFF; e_seg = 7'h7F; e_fd = 0;
    end else begin
      d = m_pos / CD;
      c = m_pos % CD;
      w = m_run ? m_snap : data_i;
      if (c < DEAD || blank_mask[d] || lzb(w, d)) begin
        e_an = 8'hFF; e_seg = 7'h7F;
      end else begin
        e_an = 8'hFF;
        e_an[d] = 1'b0;
        e_seg = HEX[(w >> (4 * d)) & 32'hF];
      end
      if (!m_run) m_snap = data_i;
      e_fd = (m_pos == FRAME - 1);
      if (e_fd) m_snap = data_i;
      m_pos = (m_pos + 1) % FRAME;
      m_run = 1;
    end
  endtask

  task automatic cycle_check();
    @(posedge clk);
    model_step();
    #1;
    check("sel",   32'(sel_o),        32'(m_pos / CD));
    check("anode", 32'(dig_an_o),     32'(e_an));
    check("seg",   32'(seg_o),        32'(e_seg));
    check("fdone", 32'(frame_done_o), 32'(e_fd));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; data_i = 32'h76543210; blank_mask = 8'h00;
    m_pos = 0; m_snap = '0; m_run = 0; e_an = 8'hFF; e_seg = 7'h7F; e_fd = 0;
    @(negedge clk);
    // Reset with en=1 held: reset values must appear regardless.
    repeat (2) cycle_check();
    check("rst_an",  32'(dig_an_o), 32'hFF);
    check("rst_seg", 32'(seg_o),    32'h7F);
    rst = 1'b0;
    // Two clean frames of 76543210, then mid-frame change to all-F.
    repeat (2 * FRAME + 10) cycle_check();
    data_i = 32'hFFFFFFFF;
    repeat (FRAME + 4) cycle_check();
    // Low digits forced dark.
    blank_mask = 8'h0F;
    repeat (FRAME) cycle_check();
    blank_mask = 8'h00;
    // Leading-zero pattern across a frame wrap.
    data_i = 32'h00000105;
    repeat (2 * FRAME) cycle_check();
    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom % 400 == 0);
      en  = ($urandom % 16 != 0);
      if ($urandom % 30 == 0) begin
        case ($urandom % 3)
          0: data_i = $urandom;
          1: data_i = $urandom & (32'hFFFFFFFF >> (4 * ($urandom % 8)));
          default: data_i = '0;
        endcase
      end
      if ($urandom % 50 == 0) blank_mask = ($urandom % 2) ? 8'(($urandom)) : 8'h00;
      cycle_check();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
